// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e    : fetch FSM states (RST, FETCH, HOLD)
//   OPCODE_HI/LO     : bit range of the opcode field inside an instruction
//   OP_BEQ           : opcode of the beq instruction
//   DEFAULT_RESET_PC : default PC value loaded on reset
// Optional build macro used by the fetch stage: FETCH_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int          OPCODE_HI        = 31;
  localparam int          OPCODE_LO        = 26;
  localparam logic [5:0]  OP_BEQ           = 6'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// -----------------------------------------------------------------------------
// pc_next_logic
// Purely combinational next-PC computation for the fetch stage.
// Ports:
//   PC           in  : address of the held instruction
//   Branch       in  : branch flag for the held instruction
//   Zero         in  : ALU zero flag for the held instruction
//   BranchOffset in  : sign-extended word offset (not yet shifted)
//   PCplus4      out : PC + 4
//   NextPC       out : branch target when Branch & Zero, else PC + 4
// All arithmetic wraps modulo 2^ADDR_W.
// -----------------------------------------------------------------------------
module pc_next_logic
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] PC,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [DATA_W-1:0] BranchOffset,
  output logic [ADDR_W-1:0] PCplus4,
  output logic [ADDR_W-1:0] NextPC
);

  logic [ADDR_W-1:0] offset_bytes_s;

  // Sequential successor and byte-scaled branch displacement
  always_comb begin
    PCplus4        = PC + ADDR_W'(4);
    // Sign-extend to address width first, then scale words to bytes.
    offset_bytes_s = ADDR_W'($signed(BranchOffset)) << 2;
  end

  // Select the taken-branch target or the sequential address
  always_comb begin
    if (Branch && Zero) begin
      NextPC = PCplus4 + offset_bytes_s;
    end else begin
      NextPC = PCplus4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: holds the PC, reads instruction words over a req/ready
// handshake, keeps the returned word until the datapath retires it, then
// advances to PC+4 or the beq target.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   IMreq, IMaddr   : instruction-memory read request and byte address (=PC)
//   IMrdata,IMready : returned word and its accept/valid strobe
//   Instr, OPcode   : held instruction and its opcode field
//   InstrValid      : Instr holds a fetched, not yet retired instruction
//   PC, PCplus4     : address of held/in-flight instruction, and PC+4
//   Advance         : datapath retires the held instruction this cycle
//   Branch, Zero    : branch decision inputs, sampled on the Advance edge
//   BranchOffset    : sign-extended word offset for the branch target
//   CycCnt,StallCnt : performance counters (only with FETCH_PERF_CNT_EN)
// Optional build macro: FETCH_PERF_CNT_EN adds the two wrapping counters.
// -----------------------------------------------------------------------------
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              IMreq,
  output logic [ADDR_W-1:0] IMaddr,
  input  logic [DATA_W-1:0] IMrdata,
  input  logic              IMready,
  output logic [DATA_W-1:0] Instr,
  output logic              InstrValid,
  output logic [5:0]        OPcode,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCplus4,
  input  logic              Advance,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [DATA_W-1:0] BranchOffset
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       CycCnt,
  output logic [31:0]       StallCnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              imreq_s;

  pc_next_logic #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pc_next (
    .PC           (pc_q),
    .Branch       (Branch),
    .Zero         (Zero),
    .BranchOffset (BranchOffset),
    .PCplus4      (pc_plus4_s),
    .NextPC       (next_pc_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (IMready) begin
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (Advance) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = RST;
      end
    endcase
  end

  // FSM outputs: request only while fetching; decoded from the state flop
  // so IMreq falls immediately with the asynchronous reset.
  always_comb begin
    imreq_s = 1'b0;
    case (state_q)
      FETCH:   imreq_s = 1'b1;
      RST:     imreq_s = 1'b0;
      HOLD:    imreq_s = 1'b0;
      default: imreq_s = 1'b0;
    endcase
  end

  // Datapath next values: capture on the ready edge, advance on retire.
  // IMready outside FETCH and Advance outside HOLD fall through unchanged.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      FETCH: begin
        if (IMready) begin
          instr_d = IMrdata;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (Advance) begin
          pc_d    = next_pc_s;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      RST: begin
        valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // PC, instruction and valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall_s;

  // A stall is a fetch cycle without data or a hold cycle without retire
  always_comb begin
    if (state_q == FETCH) begin
      stall_s = !IMready;
    end else if (state_q == HOLD) begin
      stall_s = !Advance;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Free-running wrapping cycle and stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (state_q != RST) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
      if (stall_s) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign CycCnt   = cyc_cnt_q;
  assign StallCnt = stall_cnt_q;
`endif

  assign IMreq      = imreq_s;
  assign IMaddr     = pc_q;
  assign PC         = pc_q;
  assign PCplus4    = pc_plus4_s;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign OPcode     = instr_q[OPCODE_HI:OPCODE_LO];

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the control unit. Holds the program counter and issues word reads to instruction memory over a req/ready handshake. Latches the returned instruction and presents it, with its opcode field, to the control unit and datapath. Advances the PC sequentially, or to the beq target, when the datapath retires the held instruction.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
IMreq  output  1  instruction-memory read request
IMaddr  output  ADDR_W  byte address of the requested word; equals PC
IMrdata  input  DATA_W  instruction word; valid when IMready=1
IMready  input  1  memory accepts and returns data this cycle
Instr  output  DATA_W  held instruction register
InstrValid  output  1  Instr holds a fetched, unretired instruction
OPcode  output  6  Instr[31:26], drives the control unit
PC  output  ADDR_W  address of the held/in-flight instruction
PCplus4  output  ADDR_W  PC+4
Advance  input  1  datapath retires the held instruction this cycle
Branch  input  1  control unit branch flag for the held instruction
Zero  input  1  ALU zero flag for the held instruction
BranchOffset  input  DATA_W  sign-extended inst[15:0], unshifted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: PC=RESET_PC; Instr=0; InstrValid=0; IMreq=0; state=RST.
- FSM states:
  - RST: one cycle after rst deasserts, then go to FETCH.
  - FETCH: IMreq=1, IMaddr=PC. On a rising edge with IMready=1, Instr<=IMrdata, InstrValid<=1, go to HOLD. Otherwise remain in FETCH with the address stable.
  - HOLD: IMreq=0, InstrValid=1. On a rising edge with Advance=1: PC<=NextPC, InstrValid<=0, go to FETCH. Otherwise hold Instr and PC unchanged.
- NextPC: if Branch&Zero, NextPC = PCplus4 + (BranchOffset<<2); else NextPC = PCplus4.
  - Branch, Zero and BranchOffset are sampled only on the Advance edge.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W, unsigned wrap. PC=FFFF_FFFC advances to 0000_0000. Negative offsets wrap the same way.
- Latency: minimum 2 cycles per instruction (FETCH with IMready=1, then HOLD with Advance=1). Each IMready=0 cycle adds one cycle.
- Boundary conditions:
  - Advance while InstrValid=0 is ignored.
  - IMready while IMreq=0 is ignored.
  - IMaddr must not change while IMreq=1 and IMready=0.
  - Reset mid-fetch: IMreq drops asynchronously and the outstanding request is abandoned. The bench's memory model must tolerate this.
  - Reset in HOLD: the held instruction is discarded and InstrValid=0 immediately.
- OPcode is always Instr[31:26]. After reset it reads 0, so the control unit decodes an R-type that writes $0, which is harmless. Consumers gate all side effects with InstrValid.

Optional Feature:
FETCH_PERF_CNT_EN
- With the macro: adds output ports CycCnt[31:0] and StallCnt[31:0], both reset to 0, wrapping.
  - CycCnt increments every cycle after RST.
  - StallCnt increments in FETCH with IMready=0, and in HOLD with Advance=0.
- Without the macro: neither the ports nor the counter flops exist. All other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - state enum {RST, FETCH, HOLD}
  - OPCODE_HI=31, OPCODE_LO=26
  - OP_BEQ=6'd4
  - default RESET_PC
- One combinational sub-module, pc_next_logic: inputs PC, Branch, Zero, BranchOffset; outputs PCplus4, NextPC. The instruction_fetch top keeps the FSM, registers and handshake.

Test Plan:
- Sequential fetch: reset, memory always ready, Advance=1 → IMaddr 0, 4, 8, 12 on every second cycle. Instr matches memory. InstrValid toggles 1/0.
- Wait states: IMready low for 3 cycles at addr 8 → IMaddr holds 8 and IMreq holds 1 for 4 cycles. Instr updates only on the ready edge.
- Branch taken and not taken, at PC=0x10:
  - Branch=1, Zero=1, offset=-2 → next IMaddr 0x0C.
  - Zero=0 → next IMaddr 0x14.
  - offset=+3 with Zero=1 → next IMaddr 0x20.
- Stall and wrap:
  - Advance low for 5 cycles in HOLD → Instr and PC stable.
  - RESET_PC=FFFF_FFFC with Advance → next IMaddr 0.
- Async reset mid-FETCH with IMready=0 → IMreq and InstrValid go 0 before the next edge. After release, fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN, the counters read 0 after reset.
